// File: rtl/cv32e40p_ft_err_monitor.sv
// ----------------------------------------------------------------------------
// cv32e40p_ft_err_monitor : TMR voter error statistics, replica fault tracking, alarm
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cv32e40p_ft_err_monitor #(
  parameter int CNT_W       = 8,
  parameter int PERM_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             err_detected_1_i,
  input  logic             err_detected_2_i,
  input  logic             err_detected_3_i,
  input  logic             err_corrected_i,
  input  logic             clear_i,
  input  logic             ack_i,
  output logic [CNT_W-1:0] err_cnt_1_o,
  output logic [CNT_W-1:0] err_cnt_2_o,
  output logic [CNT_W-1:0] err_cnt_3_o,
  output logic [CNT_W-1:0] corr_cnt_o,
  output logic [CNT_W-1:0] uncorr_cnt_o,
  output logic [2:0]       replica_faulty_o,
  output logic             degraded_o,
  output logic             alarm_o,
  output logic [1:0]       alarm_cause_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   THRESH_W = (CNT_W+1)'(PERM_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    REP_OK      = 2'd0,
    REP_SUSPECT = 2'd1,
    REP_FAULTY  = 2'd2
  } rep_state_e;

  typedef enum logic {
    AL_IDLE  = 1'b0,
    AL_ALARM = 1'b1
  } alarm_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [2:0] det;
  logic [1:0] det_cnt;
  logic       ev;
  logic       ev_single;
  logic       ev_uncorr;
  logic       ev_clean;

  assign det       = {err_detected_3_i, err_detected_2_i, err_detected_1_i};
  assign det_cnt   = {1'b0, det[0]} + {1'b0, det[1]} + {1'b0, det[2]};
  assign ev        = valid_i & ~clear_i;
  assign ev_single = ev && (det_cnt == 2'd1);
  assign ev_uncorr = ev && (det_cnt >= 2'd2);
  assign ev_clean  = ev && (det_cnt == 2'd0);

  logic [CNT_W-1:0] err_cnt [3];
  logic [2:0]       faulty_q;
  logic [2:0]       faulty_d;
  logic [2:0]       enter_faulty;

  for (genvar k = 0; k < 3; k++) begin : g_replica
    rep_state_e       state_q, state_d;
    logic [CNT_W-1:0] cons_q, cons_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W:0]   cons_inc;
    logic             enter_d;
    logic             hit;

    assign hit      = ev_single & det[k];
    assign cons_inc = {1'b0, cons_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
      state_d = state_q;
      cons_d  = cons_q;
      err_d   = err_q;
      enter_d = 1'b0;
      if (hit) err_d = sat_inc(err_q);
      case (state_q)
        REP_OK: begin
          if (hit) begin
            cons_d = CNT_ONE;
            if (THRESH_W <= {{CNT_W{1'b0}}, 1'b1}) begin
              state_d = REP_FAULTY;
              enter_d = 1'b1;
            end else begin
              state_d = REP_SUSPECT;
            end
          end
        end
        REP_SUSPECT: begin
          if (hit) begin
            cons_d = sat_inc(cons_q);
            if (cons_inc >= THRESH_W) begin
              state_d = REP_FAULTY;
              enter_d = 1'b1;
            end
          end else if (ev_clean || ev_single) begin
            // A clean cycle or another replica's error breaks the streak
            state_d = REP_OK;
            cons_d  = '0;
          end
        end
        default: ;
      endcase
      if (clear_i) begin
        state_d = REP_OK;
        cons_d  = '0;
        err_d   = '0;
        enter_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= REP_OK;
        cons_q  <= '0;
        err_q   <= '0;
      end else begin
        state_q <= state_d;
        cons_q  <= cons_d;
        err_q   <= err_d;
      end
    end

    assign err_cnt[k]      = err_q;
    assign faulty_q[k]     = (state_q == REP_FAULTY);
    assign faulty_d[k]     = (state_d == REP_FAULTY);
    assign enter_faulty[k] = enter_d;
  end

  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] uncorr_q, uncorr_d;
  logic             degraded_q, degraded_d;
  alarm_state_e     alarm_q, alarm_d;
  logic [1:0]       cause_q, cause_d;
  logic [1:0]       trig;

  assign trig = {ev_uncorr, |enter_faulty};

  always_comb begin
    corr_d     = corr_q;
    uncorr_d   = uncorr_q;
    alarm_d    = alarm_q;
    cause_d    = cause_q;
    degraded_d = (faulty_d[0] & faulty_d[1]) | (faulty_d[0] & faulty_d[2]) |
                 (faulty_d[1] & faulty_d[2]);
    if (ev && err_corrected_i) corr_d = sat_inc(corr_q);
    if (ev_uncorr) uncorr_d = sat_inc(uncorr_q);
    case (alarm_q)
      AL_IDLE: begin
        if (|trig) begin
          alarm_d = AL_ALARM;
          cause_d = trig;
        end
      end
      AL_ALARM: begin
        // A fresh trigger always wins over an acknowledge
        if (|trig) begin
          cause_d = cause_q | trig;
        end else if (ack_i) begin
          alarm_d = AL_IDLE;
          cause_d = 2'b00;
        end
      end
      default: ;
    endcase
    if (clear_i) begin
      corr_d   = '0;
      uncorr_d = '0;
      alarm_d  = AL_IDLE;
      cause_d  = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_q     <= '0;
      uncorr_q   <= '0;
      degraded_q <= 1'b0;
      alarm_q    <= AL_IDLE;
      cause_q    <= 2'b00;
    end else begin
      corr_q     <= corr_d;
      uncorr_q   <= uncorr_d;
      degraded_q <= degraded_d;
      alarm_q    <= alarm_d;
      cause_q    <= cause_d;
    end
  end

  assign err_cnt_1_o      = err_cnt[0];
  assign err_cnt_2_o      = err_cnt[1];
  assign err_cnt_3_o      = err_cnt[2];
  assign corr_cnt_o       = corr_q;
  assign uncorr_cnt_o     = uncorr_q;
  assign replica_faulty_o = faulty_q;
  assign degraded_o       = degraded_q;
  assign alarm_o          = (alarm_q == AL_ALARM);
  assign alarm_cause_o    = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_ft_err_monitor.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_ft_err_monitor : scoreboard bench with behavioural model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cv32e40p_ft_err_monitor;

  localparam int CNT_W = 8;
  localparam int TH    = 4;
  localparam int MAXC  = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_i = 1'b0;
  logic             err_detected_1_i = 1'b0;
  logic             err_detected_2_i = 1'b0;
  logic             err_detected_3_i = 1'b0;
  logic             err_corrected_i = 1'b0;
  logic             clear_i = 1'b0;
  logic             ack_i = 1'b0;
  logic [CNT_W-1:0] err_cnt_1_o, err_cnt_2_o, err_cnt_3_o, corr_cnt_o, uncorr_cnt_o;
  logic [2:0]       replica_faulty_o;
  logic             degraded_o, alarm_o;
  logic [1:0]       alarm_cause_o;

  cv32e40p_ft_err_monitor #(.CNT_W(CNT_W), .PERM_THRESH(TH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_i          (valid_i),
    .err_detected_1_i (err_detected_1_i),
    .err_detected_2_i (err_detected_2_i),
    .err_detected_3_i (err_detected_3_i),
    .err_corrected_i  (err_corrected_i),
    .clear_i          (clear_i),
    .ack_i            (ack_i),
    .err_cnt_1_o      (err_cnt_1_o),
    .err_cnt_2_o      (err_cnt_2_o),
    .err_cnt_3_o      (err_cnt_3_o),
    .corr_cnt_o       (corr_cnt_o),
    .uncorr_cnt_o     (uncorr_cnt_o),
    .replica_faulty_o (replica_faulty_o),
    .degraded_o       (degraded_o),
    .alarm_o          (alarm_o),
    .alarm_cause_o    (alarm_cause_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] e1, e2, e3, corr, unc;
    logic [2:0] faulty;
    logic       degr;
    logic       alarm;
    logic [1:0] cause;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;

  // Reference model: streak length per replica, sticky fault flags, alarm bookkeeping
  int       m_err[3];
  int       m_streak[3];
  bit       m_faulty[3];
  int       m_corr, m_unc;
  bit       m_alarm;
  bit [1:0] m_cause;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_err[k] = 0; m_streak[k] = 0; m_faulty[k] = 0;
    end
    m_corr = 0; m_unc = 0; m_alarm = 0; m_cause = 2'b00;
  endtask

  task automatic model(input bit r, input bit v, input bit [2:0] d, input bit c,
                       input bit cl, input bit a);
    int n;
    bit np, un;
    if (!r || cl) begin
      model_reset();
      return;
    end
    np = 0; un = 0;
    if (v) begin
      n  = int'(d[0]) + int'(d[1]) + int'(d[2]);
      un = (n >= 2);
      for (int k = 0; k < 3; k++) begin
        if (n == 1 && d[k]) m_err[k] = (m_err[k] + 1 > MAXC) ? MAXC : m_err[k] + 1;
        if (!m_faulty[k]) begin
          if (n == 1 && d[k]) begin
            m_streak[k]++;
            if (m_streak[k] >= TH) begin
              m_faulty[k] = 1;
              np = 1;
            end
          end else if (n <= 1) begin
            m_streak[k] = 0;
          end
        end
      end
      if (c)  m_corr = (m_corr + 1 > MAXC) ? MAXC : m_corr + 1;
      if (un) m_unc  = (m_unc + 1 > MAXC) ? MAXC : m_unc + 1;
    end
    if (np || un) begin
      m_alarm = 1;
      m_cause = m_cause | {un, np};
    end else if (a && m_alarm) begin
      m_alarm = 0;
      m_cause = 2'b00;
    end
  endtask

  task automatic step(input bit r, input bit v, input bit [2:0] d, input bit c,
                      input bit cl, input bit a);
    exp_t x;
    int   nf;
    @(negedge clk);
    rst_n = r; valid_i = v;
    err_detected_1_i = d[0]; err_detected_2_i = d[1]; err_detected_3_i = d[2];
    err_corrected_i = c; clear_i = cl; ack_i = a;
    model(r, v, d, c, cl, a);
    nf       = int'(m_faulty[0]) + int'(m_faulty[1]) + int'(m_faulty[2]);
    x.e1     = 8'(m_err[0]);
    x.e2     = 8'(m_err[1]);
    x.e3     = 8'(m_err[2]);
    x.corr   = 8'(m_corr);
    x.unc    = 8'(m_unc);
    x.faulty = {m_faulty[2], m_faulty[1], m_faulty[0]};
    x.degr   = (nf >= 2);
    x.alarm  = m_alarm;
    x.cause  = m_cause;
    exp_q.push_back(x);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a registered snapshot
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_x = exp_q.pop_front();
        chk("err_cnt_1", int'(err_cnt_1_o), int'(mon_x.e1));
        chk("err_cnt_2", int'(err_cnt_2_o), int'(mon_x.e2));
        chk("err_cnt_3", int'(err_cnt_3_o), int'(mon_x.e3));
        chk("corr_cnt", int'(corr_cnt_o), int'(mon_x.corr));
        chk("uncorr_cnt", int'(uncorr_cnt_o), int'(mon_x.unc));
        chk("replica_faulty", int'(replica_faulty_o), int'(mon_x.faulty));
        chk("degraded", int'(degraded_o), int'(mon_x.degr));
        chk("alarm", int'(alarm_o), int'(mon_x.alarm));
        chk("alarm_cause", int'(alarm_cause_o), int'(mon_x.cause));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [2:0] d;
    int       fav, r;
    model_reset();

    step(0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 3'b000, 0, 0, 0);
    settle();
    chk("reset_err_cnt_2", int'(err_cnt_2_o), 0);
    chk("reset_alarm", int'(alarm_o), 0);
    chk("reset_faulty", int'(replica_faulty_o), 0);

    step(1, 1, 3'b010, 1, 0, 0);
    settle();
    chk("first_err_cnt_2", int'(err_cnt_2_o), 1);
    chk("first_corr_cnt", int'(corr_cnt_o), 1);
    chk("first_alarm", int'(alarm_o), 0);

    repeat (4) step(1, 1, 3'b100, 0, 0, 0);
    settle();
    chk("r3_faulty", int'(replica_faulty_o), 4);
    chk("r3_alarm", int'(alarm_o), 1);
    chk("r3_cause", int'(alarm_cause_o), 1);
    step(1, 0, 3'b000, 0, 0, 1);
    settle();
    chk("ack_alarm", int'(alarm_o), 0);
    chk("ack_faulty_sticky", int'(replica_faulty_o), 4);

    step(1, 1, 3'b001, 0, 0, 0);
    step(1, 1, 3'b001, 0, 0, 0);
    step(1, 0, 3'b000, 0, 0, 0);
    step(1, 1, 3'b001, 0, 0, 0);
    step(1, 1, 3'b000, 0, 0, 0);
    repeat (3) step(1, 1, 3'b001, 0, 0, 0);
    settle();
    chk("r1_not_faulty", int'(replica_faulty_o[0]), 0);
    chk("r1_err_cnt", int'(err_cnt_1_o), 6);

    step(1, 1, 3'b111, 0, 0, 0);
    settle();
    chk("uncorr_cnt", int'(uncorr_cnt_o), 1);
    chk("uncorr_cause", int'(alarm_cause_o), 2);
    chk("uncorr_err_cnt_1", int'(err_cnt_1_o), 6);

    step(1, 1, 3'b001, 0, 0, 1);
    settle();
    chk("ack_lost_alarm", int'(alarm_o), 1);
    chk("ack_or_cause", int'(alarm_cause_o), 3);
    chk("r13_faulty", int'(replica_faulty_o), 5);

    repeat (300) step(1, 1, 3'b010, 0, 0, 0);
    settle();
    chk("sat_err_cnt_2", int'(err_cnt_2_o), 255);
    step(1, 1, 3'b001, 1, 1, 1);
    settle();
    chk("clear_err_cnt_1", int'(err_cnt_1_o), 0);
    chk("clear_faulty", int'(replica_faulty_o), 0);
    chk("clear_alarm", int'(alarm_o), 0);

    repeat (4) step(1, 1, 3'b001, 0, 0, 1);
    repeat (4) step(1, 1, 3'b010, 0, 0, 1);
    settle();
    chk("degraded_12", int'(degraded_o), 1);

    step(1, 0, 3'b000, 0, 1, 0);
    repeat (2) step(1, 1, 3'b100, 0, 0, 0);
    step(0, 1, 3'b100, 0, 0, 0);
    repeat (3) step(1, 1, 3'b100, 0, 0, 0);
    settle();
    chk("rst_streak_faulty", int'(replica_faulty_o), 0);
    chk("rst_err_cnt_3", int'(err_cnt_3_o), 3);
    step(1, 1, 3'b100, 0, 0, 0);
    settle();
    chk("rst_then_faulty", int'(replica_faulty_o), 4);

    fav = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) fav = int'($urandom_range(2));
      r = int'($urandom_range(99));
      if (r < 35)      d = 3'b000;
      else if (r < 85) d = 3'(1 << (($urandom_range(4) != 0) ? fav : int'($urandom_range(2))));
      else begin
        case ($urandom_range(3))
          0: d = 3'b011;
          1: d = 3'b101;
          2: d = 3'b110;
          default: d = 3'b111;
        endcase
      end
      step(($urandom_range(199) != 0), ($urandom_range(9) < 8), d, 1'($urandom_range(1)),
           ($urandom_range(149) == 0), ($urandom_range(4) == 0));
    end

    repeat (2) settle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cv32e40p_ft_err_monitor.md
Name: cv32e40p_ft_err_monitor

Overview:
- Sits directly downstream of the TMR majority voter and consumes its per-replica error flags and its corrected flag.
- Keeps saturating error statistics and tracks consecutive errors per replica.
- Declares a replica permanently faulty after a threshold of consecutive errors.
- Raises a software-acknowledged alarm on a permanent fault or an uncorrectable (all-different) event.

Parameters:
CNT_W, 8, width of every statistics counter (saturating)
PERM_THRESH, 4, consecutive errors on one replica that declare it faulty (legal range 1 .. 2^CNT_W-1)

Ports:
clk  input  1  core clock
rst_n  input  1  reset, synchronous active-low
valid_i  input  1  voter outputs are meaningful this cycle; all other inputs are ignored when 0
err_detected_1_i  input  1  replica 1 disagreed
err_detected_2_i  input  1  replica 2 disagreed
err_detected_3_i  input  1  replica 3 disagreed
err_corrected_i  input  1  voter masked a single-replica error
clear_i  input  1  software clear of counters, replica states and alarm
ack_i  input  1  software acknowledge of alarm
err_cnt_1_o  output  CNT_W  attributed error count, replica 1
err_cnt_2_o  output  CNT_W  attributed error count, replica 2
err_cnt_3_o  output  CNT_W  attributed error count, replica 3
corr_cnt_o  output  CNT_W  count of corrected events
uncorr_cnt_o  output  CNT_W  count of uncorrectable events
replica_faulty_o  output  3  sticky permanent-fault flag per replica (bit0 = replica 1)
degraded_o  output  1  two or more replica_faulty_o bits set
alarm_o  output  1  alarm pending, level
alarm_cause_o  output  2  00 none, 01 permanent fault, 10 uncorrectable, 11 both in same cycle

Behaviour:
- All outputs are registered. A sampled event is visible on the outputs in the cycle after valid_i=1.
- Reset (rst_n=0 at a clk edge): all counters 0, replica_faulty_o=000, degraded_o=0, alarm_o=0, alarm_cause_o=00, all replica FSMs OK, consecutive counters 0. Reset mid-operation discards any in-flight event.
- Event classification, only when valid_i=1 and clear_i=0:
  - Exactly one err_detected bit set = single error, attributed to that replica.
  - Two or more bits set = uncorrectable, not attributed to any replica.
  - No bits set = clean.
- Counters (all saturate at 2^CNT_W-1, no wrap):
  - Single error: err_cnt_k +1.
  - err_corrected_i=1: corr_cnt +1.
  - Uncorrectable: uncorr_cnt +1.
- Per-replica FSM, states OK / SUSPECT / FAULTY, with a consecutive counter cons_k (width CNT_W, saturating):
  - OK: single error on k -> SUSPECT, cons_k=1. If PERM_THRESH=1, go directly to FAULTY instead.
  - SUSPECT: single error on k -> cons_k+1; if cons_k+1 >= PERM_THRESH -> FAULTY.
  - SUSPECT: clean cycle, or single error on another replica -> OK, cons_k=0.
  - OK/SUSPECT: uncorrectable event -> no change (neither advances nor resets cons_k).
  - FAULTY: sticky; leaves only on clear_i or reset. Its error counter keeps counting.
  - valid_i=0: no state change.
- replica_faulty_o[k] = (state_k==FAULTY). degraded_o = popcount(replica_faulty_o) >= 2.
- Alarm FSM, states IDLE / ALARM:
  - Trigger = a replica's transition into FAULTY this cycle, or an uncorrectable event.
  - IDLE + trigger -> ALARM; alarm_cause_o set from the trigger (11 if both kinds occur in one cycle).
  - ALARM + ack_i, no trigger -> IDLE, cause 00.
  - ALARM + new trigger (with or without ack_i) -> stay ALARM; cause ORed with the new trigger kind. A trigger is never lost to an ack.
  - ack_i in IDLE: no effect.
- clear_i=1: next cycle identical to reset values. clear_i has priority over any event in the same cycle (the event is dropped) and over ack_i.
- Counters remain readable at all times; no handshake on them.

Test Plan:
- Reset -> all outputs 0. Then valid_i=1 with err_detected_2_i=1, err_corrected_i=1 for 1 cycle -> next cycle err_cnt_2_o=1, corr_cnt_o=1, alarm_o=0.
- Replica 3 errors on 4 consecutive valid cycles (PERM_THRESH=4) -> replica_faulty_o=100 and alarm_o=1, alarm_cause_o=01 after the 4th; ack_i -> alarm_o=0 next cycle; replica_faulty_o stays 100.
- Replica 1: 3 errors, 1 clean cycle, 3 errors -> replica_faulty_o[0]=0, err_cnt_1_o=6; a gap with valid_i=0 between errors does not break the streak.
- All three detect bits set -> uncorr_cnt_o=1, alarm_cause_o=10, err_cnt_k unchanged. A single error arriving in the same cycle as ack_i while in ALARM -> the alarm remains, with the cause ORed.
- 300 single errors on replica 2 with CNT_W=8 -> err_cnt_2_o saturates at 255. clear_i asserted together with a replica-1 error -> all outputs 0 next cycle, err_cnt_1_o=0.
- Replicas 1 and 2 both driven to FAULTY -> degraded_o=1. Synchronous rst_n low for 1 cycle mid-streak -> all state cleared, cons counters 0.
